// File: rtl/multicycle_alu.sv
// Parametrised ALU with registered results behind a Start/Busy/Done handshake.
// Single-cycle ops finish at the accept edge; unsigned MUL iterates WIDTH cycles.
module multicycle_alu #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       FunSel,
    input  logic             WF,
    input  logic             Start,
    output logic [WIDTH-1:0] ALUOut,
    output logic [WIDTH-1:0] ALUOutHi,
    output logic [3:0]       FlagsOut,
    output logic             Busy,
    output logic             Done
);

    localparam logic [4:0] OP_PASSA = 5'h00;
    localparam logic [4:0] OP_PASSB = 5'h01;
    localparam logic [4:0] OP_NOTA  = 5'h02;
    localparam logic [4:0] OP_NOTB  = 5'h03;
    localparam logic [4:0] OP_ADD   = 5'h04;
    localparam logic [4:0] OP_ADC   = 5'h05;
    localparam logic [4:0] OP_SUB   = 5'h06;
    localparam logic [4:0] OP_AND   = 5'h07;
    localparam logic [4:0] OP_OR    = 5'h08;
    localparam logic [4:0] OP_XOR   = 5'h09;
    localparam logic [4:0] OP_NAND  = 5'h0A;
    localparam logic [4:0] OP_LSL   = 5'h0B;
    localparam logic [4:0] OP_LSR   = 5'h0C;
    localparam logic [4:0] OP_ASR   = 5'h0D;
    localparam logic [4:0] OP_CSL   = 5'h0E;
    localparam logic [4:0] OP_CSR   = 5'h0F;
    localparam logic [4:0] OP_MUL   = 5'h10;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t state, state_next;

    logic               accept;
    logic               mul_last;
    logic [WIDTH-1:0]   alu_res;
    logic [3:0]         alu_flags;
    logic [WIDTH:0]     sum_w;
    logic               c_new;
    logic               o_new;
    logic               reserved;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               mul_wf;
    logic               hi_nz;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (Start && FunSel == OP_MUL) state_next = MUL;
            MUL:  if (cnt == CNT_ONE) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy     = (state == MUL);
        accept   = Start && (state == IDLE);
        mul_last = (state == MUL) && (cnt == CNT_ONE);
    end

    // Single-cycle result and flags; C and O default to their held values.
    always_comb begin
        alu_res  = '0;
        sum_w    = '0;
        c_new    = FlagsOut[2];
        o_new    = FlagsOut[0];
        reserved = 1'b0;
        case (FunSel)
            OP_PASSA: alu_res = A;
            OP_PASSB: alu_res = B;
            OP_NOTA:  alu_res = ~A;
            OP_NOTB:  alu_res = ~B;
            OP_ADD: begin
                sum_w   = {1'b0, A} + {1'b0, B};
                alu_res = sum_w[WIDTH-1:0];
                c_new   = sum_w[WIDTH];
                o_new   = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_ADC: begin
                sum_w   = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, FlagsOut[2]};
                alu_res = sum_w[WIDTH-1:0];
                c_new   = sum_w[WIDTH];
                o_new   = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sum_w   = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum_w[WIDTH-1:0];
                c_new   = sum_w[WIDTH];
                o_new   = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_NAND: alu_res = ~(A & B);
            OP_LSL: begin
                alu_res = {A[WIDTH-2:0], 1'b0};
                c_new   = A[WIDTH-1];
            end
            OP_LSR: begin
                alu_res = {1'b0, A[WIDTH-1:1]};
                c_new   = A[0];
            end
            OP_ASR: begin
                alu_res = {A[WIDTH-1], A[WIDTH-1:1]};
                c_new   = A[0];
            end
            OP_CSL: begin
                alu_res = {A[WIDTH-2:0], A[WIDTH-1]};
                c_new   = A[WIDTH-1];
            end
            OP_CSR: begin
                alu_res = {A[0], A[WIDTH-1:1]};
                c_new   = A[0];
            end
            default: reserved = 1'b1;
        endcase
        alu_flags = reserved ? FlagsOut
                             : {(alu_res == '0), c_new, alu_res[WIDTH-1], o_new};
    end

    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
        hi_nz    = (acc_next[2*WIDTH-1:WIDTH] != '0);
    end

    // Result registers and the shift-add multiplier datapath.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            ALUOut   <= '0;
            ALUOutHi <= '0;
            FlagsOut <= '0;
            Done     <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            mul_wf   <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (accept) begin
                if (FunSel == OP_MUL) begin
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, A};
                    mplier <= B;
                    cnt    <= CNT_INIT;
                    mul_wf <= WF;
                end else begin
                    ALUOut   <= alu_res;
                    ALUOutHi <= '0;
                    if (WF) FlagsOut <= alu_flags;
                    Done     <= 1'b1;
                end
            end else if (state == MUL) begin
                acc    <= acc_next;
                mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                mplier <= {1'b0, mplier[WIDTH-1:1]};
                cnt    <= cnt - CNT_ONE;
                if (mul_last) begin
                    ALUOut   <= acc_next[WIDTH-1:0];
                    ALUOutHi <= acc_next[2*WIDTH-1:WIDTH];
                    if (mul_wf) FlagsOut <= {(acc_next == '0), hi_nz, 1'b0, hi_nz};
                    Done     <= 1'b1;
                end
            end
        end
    end

endmodule
